// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store memory master.
// Holds the FSM state enum, access-size codes and the default wait limit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10,
    ST_RESP    = 2'b11
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int TIMEOUT_DEFAULT = 64;

  // Reserved size or a half/word that is not naturally aligned.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask and replication, load lane select and extension.
// Purely combinational; fed from the latched request fields.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    case (size)
      SZ_BYTE: begin
        st_mask  = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = load_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        st_mask  = 4'b0011 << {addr_lo[1], 1'b0};
        st_lanes = {2{st_data[15:0]}};
        ld_data  = load_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        st_mask  = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one outstanding access, word-indexed memory
// channels, lane alignment, and a wait-cycle timeout that aborts with an error.
//
//   state      | meaning
//   ST_IDLE    | ready for a request; misaligned/reserved goes straight to ST_RESP
//   ST_RD_WAIT | rreq high, waiting for data_valid or timeout
//   ST_WR_WAIT | wreq high, waiting for write_done or timeout
//   ST_RESP    | one-cycle resp_valid pulse, then back to ST_IDLE
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        rreq,
  output logic [31:0] raddr,
  input  logic [31:0] rdata,
  input  logic        data_valid,
  output logic        wreq,
  output logic [31:0] waddr,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  input  logic        write_done
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  lsu_lane_align u_lane (
    .size          (size_q),
    .addr_lo       (addr_q[1:0]),
    .load_unsigned (uns_q),
    .st_data       (wdata_q),
    .ld_word       (rdata),
    .st_mask       (lane_mask),
    .st_lanes      (lane_wdata),
    .ld_data       (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d       = req_addr;
          size_d       = req_size;
          uns_d        = req_unsigned;
          we_d         = req_we;
          wdata_d      = req_wdata;
          cnt_d        = 8'd0;
          resp_rdata_d = 32'h0;
          resp_err_d   = access_err(req_size, req_addr[1:0]);
          if (access_err(req_size, req_addr[1:0])) state_d = ST_RESP;
          else if (req_we)                         state_d = ST_WR_WAIT;
          else                                     state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // Completion is checked first so it beats a coincident timeout.
        if (data_valid) begin
          state_d      = ST_RESP;
          resp_rdata_d = lane_rdata;
          resp_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          resp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WR_WAIT: begin
        if (write_done) begin
          state_d    = ST_RESP;
          resp_err_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          resp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'h0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      cnt_q        <= 8'd0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign req_ready  = (state_q == ST_IDLE) && reset;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign rreq  = (state_q == ST_RD_WAIT);
  assign wreq  = (state_q == ST_WR_WAIT);
  assign raddr = rreq ? {2'b00, addr_q[31:2]} : 32'h0;
  assign waddr = wreq ? {2'b00, addr_q[31:2]} : 32'h0;
  assign wmask = wreq ? lane_mask : 4'h0;
  assign wdata = wreq ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: aligned/misaligned loads and stores,
// lane extension, timeout boundary, stray handshakes and mid-access reset.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        rreq, data_valid, wreq, write_done;
  logic [31:0] raddr, rdata, waddr, wdata;
  logic [3:0]  wmask;

  int n_assert = 0;
  int n_fail   = 0;

  int          lat, req_cycles;
  logic        err_o, chan_ok, saw;
  logic [31:0] rd_o, obs_wdata;
  logic [3:0]  obs_wmask;

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .rreq(rreq), .raddr(raddr), .rdata(rdata), .data_valid(data_valid),
    .wreq(wreq), .waddr(waddr), .wmask(wmask), .wdata(wdata),
    .write_done(write_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and emulate memory answering after 'delay' wait cycles
  // (delay < 0: never answers). lat = cycles from accept to resp_valid.
  task automatic run_access(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int delay, input logic [31:0] mem_word);
    chk("accept_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; req_cycles = 0; chan_ok = 1'b1; err_o = 1'b0; rd_o = 32'hx;
    obs_wmask = 4'h0; obs_wdata = 32'h0;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      data_valid = !we && (n == 1 + delay);
      write_done =  we && (n == 1 + delay);
      rdata      = data_valid ? mem_word : 32'h5A5A5A5A;
      @(negedge clk);
      if (rreq || wreq) begin
        req_cycles++;
        if (we ? rreq : wreq) chan_ok = 1'b0;
        if (rreq && raddr !== {2'b00, addr[31:2]}) chan_ok = 1'b0;
        if (wreq && waddr !== {2'b00, addr[31:2]}) chan_ok = 1'b0;
        obs_wmask = wmask; obs_wdata = wdata;
      end
      if (resp_valid) begin
        lat = n; err_o = resp_err; rd_o = resp_rdata;
      end
      @(posedge clk); #1;
    end
    data_valid = 1'b0; write_done = 1'b0;
    if (lat < 0) chk("resp_timeout_bound", 32'h0, 32'h1);
    chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    data_valid = 1'b0; write_done = 1'b0; rdata = 32'h0;

    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rreq", {31'h0, rreq}, 32'h0);
    chk("rst_wreq", {31'h0, wreq}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk); reset = 1'b1; #1;
    chk("rel_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;

    // Load word 0x10, 5 wait cycles
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 32'hDEADBEEF);
    chk("lw_lat", lat, 7);
    chk("lw_rdata", rd_o, 32'hDEADBEEF);
    chk("lw_err", {31'h0, err_o}, 32'h0);
    chk("lw_rreq_cycles", req_cycles, 6);
    chk("lw_raddr", {31'h0, chan_ok}, 32'h1);

    run_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 32'h80FF7F01);
    chk("lb_signed", rd_o, 32'hFFFFFF80);
    chk("lb_lat0", lat, 2);
    run_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 32'h80FF7F01);
    chk("lbu", rd_o, 32'h00000080);
    run_access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 32'h80FF7F01);
    chk("lb_lane1", rd_o, 32'h0000007F);
    run_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1, 32'h80FF7F01);
    chk("lh_signed_hi", rd_o, 32'hFFFF80FF);
    run_access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1, 32'h80FF7F01);
    chk("lhu_lo", rd_o, 32'h00007F01);

    // Stores
    run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 3, 32'h0);
    chk("sh_wmask", obs_wmask, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hABCDABCD);
    chk("sh_waddr", {31'h0, chan_ok}, 32'h1);
    chk("sh_err", {31'h0, err_o}, 32'h0);
    chk("sh_rdata", rd_o, 32'h0);
    chk("sh_lat", lat, 5);
    run_access(1'b1, 2'b00, 1'b0, 32'h05, 32'hCAFE0077, 0, 32'h0);
    chk("sb_wmask", obs_wmask, 4'b0010);
    chk("sb_wdata", obs_wdata, 32'h77777777);
    chk("sb_waddr", {31'h0, chan_ok}, 32'h1);
    run_access(1'b1, 2'b10, 1'b0, 32'h08, 32'h01234567, 1, 32'h0);
    chk("sw_wmask", obs_wmask, 4'b1111);
    chk("sw_wdata", obs_wdata, 32'h01234567);

    // Error cases: no memory request, response next cycle
    run_access(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 0, 32'h11111111);
    chk("mis_lh_lat", lat, 1);
    chk("mis_lh_err", {31'h0, err_o}, 32'h1);
    chk("mis_lh_rdata", rd_o, 32'h0);
    chk("mis_lh_noreq", req_cycles, 0);
    run_access(1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFFFFFF, 0, 32'h0);
    chk("mis_sw_err", {31'h0, err_o}, 32'h1);
    chk("mis_sw_noreq", req_cycles, 0);
    run_access(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 0, 32'h0);
    chk("rsvd_err", {31'h0, err_o}, 32'h1);
    chk("rsvd_lat", lat, 1);

    // Timeout: memory never answers
    run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, -1, 32'h0);
    chk("to_rreq_cycles", req_cycles, 64);
    chk("to_lat", lat, 65);
    chk("to_err", {31'h0, err_o}, 32'h1);
    chk("to_rdata", rd_o, 32'h0);
    run_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 2, 32'h600DF00D);
    chk("after_to_rdata", rd_o, 32'h600DF00D);
    chk("after_to_err", {31'h0, err_o}, 32'h0);

    // Completion on the last allowed wait cycle beats the timeout
    run_access(1'b1, 2'b10, 1'b0, 32'h48, 32'h0, 63, 32'h0);
    chk("edge_wr_err", {31'h0, err_o}, 32'h0);
    chk("edge_wr_lat", lat, 65);
    chk("edge_wr_cycles", req_cycles, 64);

    // Stray completion strobes in IDLE are ignored
    data_valid = 1'b1; write_done = 1'b1; rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stray_resp", {31'h0, resp_valid}, 32'h0);
    chk("stray_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    chk("stray_resp2", {31'h0, resp_valid}, 32'h0);
    data_valid = 1'b0; write_done = 1'b0;

    // Reset in the middle of RD_WAIT abandons the access
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h80;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_rreq_before", {31'h0, rreq}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rreq_async", {31'h0, rreq}, 32'h0);
    chk("mid_raddr_async", raddr, 32'h0);
    chk("mid_ready_in_rst", {31'h0, req_ready}, 32'h0);
    @(negedge clk); #2 reset = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid || rreq) saw = 1'b1;
    end
    chk("mid_no_resp", {31'h0, saw}, 32'h0);
    chk("mid_ready_after", {31'h0, req_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles waiting for data_valid/write_done before abort (legal range 2..255).
REQ-002 SHALL have port clk  in  1  single clock; all flops rising-edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  pipeline access request.
REQ-005 SHALL have port req_ready  out  1  request accepted when req_valid&&req_ready.
REQ-006 SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, LSB-aligned.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  misaligned, reserved size, or timeout.
REQ-014 SHALL have ports rreq out 1, raddr out 32, rdata in 32, data_valid in 1: memory read channel.
REQ-015 SHALL have ports wreq out 1, waddr out 32, wmask out 4, wdata out 32, write_done in 1: memory write channel.

Function
REQ-016 SHALL implement FSM IDLE, RD_WAIT, WR_WAIT, RESP; req_ready=1 only in IDLE.
REQ-017 On accept in IDLE SHALL latch addr, size, unsigned, we, wdata; load -> RD_WAIT, store -> WR_WAIT, error case -> RESP directly.
REQ-018 Error case SHALL be: size 11; size 01 with addr[0]=1; size 10 with addr[1:0]!=0; no memory request is issued.
REQ-019 raddr/waddr SHALL be latched addr[31:2] zero-extended (word index), stable for the whole wait state.
REQ-020 rreq SHALL be 1 exactly in RD_WAIT; wreq SHALL be 1 exactly in WR_WAIT; both driven from state, never combinationally from inputs.
REQ-021 RD_WAIT with data_valid=1 SHALL capture rdata and go to RESP; WR_WAIT with write_done=1 SHALL go to RESP.
REQ-022 wmask SHALL be byte: 4'b0001<<addr[1:0]; half: 4'b0011<<{addr[1],1'b0}; word: 4'b1111.
REQ-023 wdata SHALL be byte replicated x4, half replicated x2, word unchanged.
REQ-024 Load SHALL select byte lane addr[1:0] / half lane addr[1], then sign- or zero-extend to 32 bits.
REQ-025 Wait counter SHALL clear on entry to RD_WAIT/WR_WAIT, increment each wait cycle; at count==TIMEOUT-1 with no completion SHALL go to RESP with resp_err=1, dropping rreq/wreq.
REQ-026 Completion and timeout in same cycle: completion wins, resp_err=0.
REQ-027 RESP SHALL last exactly one cycle with resp_valid=1, then IDLE; rreq/wreq therefore low for at least two cycles between accesses.
REQ-028 Latency: accept at cycle T, memory completion at T+1+k -> resp_valid at T+2+k; error case -> resp_valid at T+1.
REQ-029 data_valid/write_done outside the matching wait state SHALL be ignored.

Reset
REQ-030 Reset low SHALL immediately force IDLE, counter 0, and all outputs 0 except req_ready, which goes to 1 once reset deasserts; an in-flight access is abandoned with no response.

Structure
REQ-031 Shared package lsu_pkg SHALL hold the state enum, size encodings and TIMEOUT default.
REQ-032 Lane logic (mask, store replication, load extract/extend) SHALL be one combinational sub-module lsu_lane_align.

Verification
REQ-033 Load word addr 0x10, memory word 4 = 0xDEADBEEF, delay 5 -> raddr=4 held, resp_rdata=0xDEADBEEF, resp_valid at T+7.
REQ-034 Signed load byte addr 0x13, word = 0x80FF7F01 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Store half 0x1234ABCD addr 0x22 -> waddr=8, wmask=4'b1100, wdata=0xABCDABCD, resp_err=0.
REQ-036 Load half addr 0x01 -> no rreq, resp_valid at T+1, resp_err=1, resp_rdata=0.
REQ-037 Memory never answers, TIMEOUT=64 -> rreq high 64 cycles, then resp_err=1; next request accepted normally.
REQ-038 Reset pulsed mid RD_WAIT -> rreq low asynchronously, no resp_valid, req_ready=1 after release.
